// File: rtl/uart_mem_bridge_pkg.sv
// Shared constants, state encoding and helpers for the UART-to-memory bridge.
package uart_mem_bridge_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;

  localparam logic [1:0] WE_NONE = 2'b00;
  localparam logic [1:0] WE_WORD = 2'b01;

  localparam logic [2:0] RM_WORD = 3'b000;
  localparam logic [2:0] RM_IDLE = 3'b111;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR0,
    S_ADDR1,
    S_ADDR2,
    S_ADDR3,
    S_LEN,
    S_WDATA,
    S_RREAD,
    S_RSEND
  } state_t;

  // States in which the host owes us another byte and a stall is an abort.
  function automatic logic is_timed(input state_t s);
    case (s)
      S_ADDR0, S_ADDR1, S_ADDR2, S_ADDR3, S_LEN, S_WDATA: return 1'b1;
      default:                                          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_mem_bridge_byte_timeout.sv
// Inter-byte idle counter: saturates and flags expiry after TIMEOUT_CYCLES idle cycles.
module byte_timeout #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = (cnt == CW'(TIMEOUT_CYCLES));

endmodule

// File: rtl/uart_mem_bridge.sv
// UART byte-stream to memory-port initiator: 'W'/'R' frames become word writes/reads.
module uart_mem_bridge
  import uart_mem_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [7:0]            tx_data,
  output logic [1:0]            mem_we,
  output logic [2:0]            mem_readmode,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wd,
  input  logic [31:0]           mem_rd,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  state_t state, state_d;

  logic                  is_write_q;
  logic [31:0]           addr_q;
  logic [31:0]           wbuf_q;
  logic [31:0]           rword_q;
  logic [31:0]           wd_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [8:0]            count_q;
  logic [1:0]            bcnt_q;
  logic [1:0]            k_q;
  logic                  we_q, done_q, err_q;

  logic done_d, err_d, wr_fire, tx_fire;
  logic expired, tmo_en, last_word;

  assign last_word = (count_q == 9'd1);
  assign tmo_en    = is_timed(state);

  byte_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (rx_valid || !tmo_en),
    .enable  (tmo_en),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    done_d  = 1'b0;
    err_d   = 1'b0;
    wr_fire = 1'b0;
    tx_fire = 1'b0;
    case (state)
      S_IDLE: begin
        if (rx_valid) begin
          if (rx_data == CMD_WRITE || rx_data == CMD_READ) state_d = S_ADDR0;
          else                                             err_d   = 1'b1;
        end
      end
      S_ADDR0: if (rx_valid) state_d = S_ADDR1;
      S_ADDR1: if (rx_valid) state_d = S_ADDR2;
      S_ADDR2: if (rx_valid) state_d = S_ADDR3;
      S_ADDR3: if (rx_valid) state_d = S_LEN;
      S_LEN:   if (rx_valid) state_d = is_write_q ? S_WDATA : S_RREAD;
      S_WDATA: begin
        if (rx_valid && bcnt_q == 2'd3) begin
          wr_fire = 1'b1;
          if (last_word) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      S_RREAD: state_d = S_RSEND;
      S_RSEND: begin
        if (tx_ready) begin
          tx_fire = 1'b1;
          if (k_q == 2'd3) begin
            if (last_word) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = S_RREAD;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A byte arriving on the expiry cycle still counts; only a true stall aborts.
    if (tmo_en && !rx_valid && expired) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      is_write_q <= 1'b0;
      addr_q     <= '0;
      wbuf_q     <= '0;
      rword_q    <= '0;
      wd_q       <= '0;
      waddr_q    <= '0;
      count_q    <= '0;
      bcnt_q     <= '0;
      k_q        <= '0;
      we_q       <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      we_q   <= wr_fire;
      done_q <= done_d;
      err_q  <= err_d;
      case (state)
        S_IDLE: if (rx_valid) is_write_q <= (rx_data == CMD_WRITE);
        S_ADDR0, S_ADDR1, S_ADDR2, S_ADDR3: if (rx_valid) addr_q <= {rx_data, addr_q[31:8]};
        S_LEN: begin
          if (rx_valid) begin
            count_q <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
            bcnt_q  <= 2'd0;
          end
        end
        S_WDATA: begin
          if (rx_valid) begin
            wbuf_q <= {rx_data, wbuf_q[31:8]};
            bcnt_q <= bcnt_q + 2'd1;
          end
        end
        S_RREAD: begin
          rword_q <= mem_rd;
          k_q     <= 2'd0;
        end
        S_RSEND: if (tx_fire) k_q <= k_q + 2'd1;
        default: ;
      endcase
      if (wr_fire) begin
        wd_q    <= {rx_data, wbuf_q[31:8]};
        waddr_q <= addr_q[ADDR_WIDTH-1:0];
      end
      // 32-bit increment; slicing to ADDR_WIDTH gives the narrower wrap for free.
      if (wr_fire || (tx_fire && k_q == 2'd3)) begin
        addr_q  <= addr_q + 32'd4;
        count_q <= count_q - 9'd1;
      end
    end
  end

  assign mem_we       = we_q ? WE_WORD : WE_NONE;
  assign mem_wd       = wd_q;
  assign mem_readmode = (state == S_RREAD) ? RM_WORD : RM_IDLE;
  assign mem_addr     = (state == S_RREAD) ? addr_q[ADDR_WIDTH-1:0] : waddr_q;
  assign tx_valid     = (state == S_RSEND);
  assign tx_data      = rword_q[{k_q, 3'b000} +: 8];
  assign busy         = (state != S_IDLE);
  assign done         = done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_uart_mem_bridge.sv
// Randomized bench for uart_mem_bridge: frame-level reference model with a behavioural memory slave.
module tb_uart_mem_bridge;

  localparam int AW  = 32;
  localparam int TMO = 50;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          tx_ready = 1'b1;
  logic [31:0]   mem_rd = 32'h0;
  logic          tx_valid;
  logic [7:0]    tx_data;
  logic [1:0]    mem_we;
  logic [2:0]    mem_readmode;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wd;
  logic          busy, done, err;

  always #5 clk = ~clk;

  uart_mem_bridge #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .mem_we(mem_we), .mem_readmode(mem_readmode), .mem_addr(mem_addr),
    .mem_wd(mem_wd), .mem_rd(mem_rd), .busy(busy), .done(done), .err(err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory slave and passive monitor, sampled on the falling edge.
  logic [31:0] slave   [bit [31:0]];
  logic [31:0] exp_mem [bit [31:0]];
  logic [31:0] we_addr_q[$];
  logic [31:0] we_data_q[$];
  logic [7:0]  txq[$];
  int done_cnt = 0, err_cnt = 0, both_cnt = 0, busy_cnt = 0, bad_we = 0;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'hBAD0_0000;
  endfunction

  always @(negedge clk) begin
    if (mem_we == 2'b01) begin
      slave[mem_addr] = mem_wd;
      we_addr_q.push_back(mem_addr);
      we_data_q.push_back(mem_wd);
    end
    if (mem_we != 2'b00 && mem_we != 2'b01) bad_we++;
    if (tx_valid && tx_ready) txq.push_back(tx_data);
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (done && err) both_cnt++;
    if (busy) busy_cnt++;
    if (mem_readmode == 3'b000)
      mem_rd = slave.exists(mem_addr) ? slave[mem_addr] : dflt(mem_addr);
    else
      mem_rd = 32'h0;
  end

  // Transmitter model: ready always, randomly, or held low for one 5-cycle stall on byte 2.
  bit rnd_ready = 1'b0, hold_en = 1'b0, hold_used = 1'b0;
  int hold_left = 0, hold_cycles = 0, hold_bad = 0, rd_base = 0;

  always @(posedge clk) begin
    #1;
    if (hold_en && !hold_used && tx_valid && (txq.size() - rd_base) == 2) begin
      hold_used = 1'b1;
      hold_left = 5;
    end
    if (hold_left > 0) begin
      tx_ready = 1'b0;
      hold_left--;
      hold_cycles++;
      if (!tx_valid || tx_data !== 8'hAD) hold_bad++;
    end else begin
      tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // All stimulus tasks run in the posedge+1 phase.
  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [31:0] a, input int n);
    send_byte(cmd);
    for (int j = 0; j < 4; j++) send_byte(a[8*j +: 8]);
    send_byte(8'(n));
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int i = 0;
    while (busy && i < budget) begin @(posedge clk); #1; i++; end
    check({tag, "_idle"}, 32'(busy), 32'd0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic do_write(input string tag, input logic [31:0] a, input int n);
    logic [31:0] words[$];
    int wb = we_addr_q.size();
    int db = done_cnt;
    int eb = err_cnt;
    send_hdr(8'h57, a, n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] w = (tag == "t1") ? ((i == 0) ? 32'hDEADBEEF : 32'h12345678) : $urandom;
      words.push_back(w);
      exp_mem[a + 32'(4 * i)] = w;
      for (int j = 0; j < 4; j++) send_byte(w[8*j +: 8]);
    end
    wait_idle(tag, 200);
    check({tag, "_wr_count"}, 32'(we_addr_q.size() - wb), 32'(n));
    for (int i = 0; i < n && wb + i < we_addr_q.size(); i++) begin
      check({tag, "_wr_addr"}, we_addr_q[wb + i], a + 32'(4 * i));
      check({tag, "_wr_data"}, we_data_q[wb + i], words[i]);
    end
    check({tag, "_wr_done"}, 32'(done_cnt - db), 32'd1);
    check({tag, "_wr_err"}, 32'(err_cnt - eb), 32'd0);
  endtask

  task automatic do_read(input string tag, input logic [31:0] a, input int n);
    int db = done_cnt;
    rd_base = txq.size();
    send_hdr(8'h52, a, n);
    wait_idle(tag, 64 * n + 200);
    check({tag, "_rd_count"}, 32'(txq.size() - rd_base), 32'(4 * n));
    for (int i = 0; i < n; i++) begin
      logic [31:0] wa = a + 32'(4 * i);
      logic [31:0] w  = exp_mem.exists(wa) ? exp_mem[wa] : dflt(wa);
      for (int j = 0; j < 4; j++)
        if (rd_base + 4 * i + j < txq.size())
          check({tag, "_rd_byte"}, 32'(txq[rd_base + 4 * i + j]), 32'(w[8*j +: 8]));
    end
    check({tag, "_rd_done"}, 32'(done_cnt - db), 32'd1);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not reach the end, n_fail=%0d", n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int eb, wb, db, bb, i;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_readmode", 32'(mem_readmode), 32'h7);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wd", mem_wd, 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Two-word write, then read back with a 5-cycle stall on byte 2.
    do_write("t1", 32'h10, 2);
    check("t1_busy_after", 32'(busy), 32'd0);
    hold_en = 1'b1;
    do_read("t2", 32'h10, 2);
    hold_en = 1'b0;
    check("t2_hold_cycles", 32'(hold_cycles), 32'd5);
    check("t2_hold_stable", 32'(hold_bad), 32'd0);

    // Bad command byte.
    eb = err_cnt; wb = we_addr_q.size(); bb = busy_cnt;
    send_byte(8'h41);
    repeat (3) begin @(posedge clk); #1; end
    check("t3_err", 32'(err_cnt - eb), 32'd1);
    check("t3_busy", 32'(busy_cnt - bb), 32'd0);
    check("t3_no_we", 32'(we_addr_q.size() - wb), 32'd0);
    do_write("t3w", 32'h40, 1);

    // Stalled frame after two data bytes.
    eb = err_cnt; wb = we_addr_q.size(); db = done_cnt;
    send_hdr(8'h57, 32'h30, 1);
    send_byte(8'h11);
    send_byte(8'h22);
    repeat (TMO + 20) begin @(posedge clk); #1; end
    check("t4_err", 32'(err_cnt - eb), 32'd1);
    check("t4_no_we", 32'(we_addr_q.size() - wb), 32'd0);
    check("t4_no_done", 32'(done_cnt - db), 32'd0);
    check("t4_busy", 32'(busy), 32'd0);
    do_write("t4w", 32'h20, 1);
    do_read("t4r", 32'h20, 1);

    // Address wrap and LEN=0 meaning 256 words.
    do_write("t5wrap", 32'hFFFF_FFFC, 2);
    do_write("t5len0", 32'h0000_1000, 256);
    rnd_ready = 1'b1;
    do_read("t5rwrap", 32'hFFFF_FFFC, 2);
    do_read("t5rlen0", 32'h0000_13F4, 3);

    // Reset while the second byte of a read is on the wire.
    rnd_ready = 1'b0;
    rd_base = txq.size();
    send_hdr(8'h52, 32'h10, 2);
    i = 0;
    while (!((txq.size() - rd_base) >= 1 && tx_valid) && i < 200) begin
      @(posedge clk); #1; i++;
    end
    check("t6_reach_byte1", 32'((txq.size() - rd_base) >= 1 && tx_valid), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("t6_tx_valid", 32'(tx_valid), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_readmode", 32'(mem_readmode), 32'h7);
    check("t6_we", 32'(mem_we), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    do_read("t6r", 32'h10, 2);

    // Random frames at arbitrary addresses, read back with random backpressure.
    rnd_ready = 1'b1;
    for (int r = 0; r < 4; r++) begin
      logic [31:0] a = $urandom;
      int n = $urandom_range(1, 4);
      do_write("rnd_w", a, n);
      do_read("rnd_r", a, n);
    end

    check("done_err_overlap", 32'(both_cnt), 32'd0);
    check("we_encoding", 32'(bad_we), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
